bank_account_server: RTL and testbench
======================================

Name: bank_account_server

Overview:
- Bank-side responder serving transaction requests from the ATM controller.
- Holds a small register file of accounts (balance, PIN, wrong-PIN try count, lock flag).
- Authenticates the card, tracks one open session, and applies withdraw, deposit and inquiry with bounds checks.
- Returns one status plus the resulting balance per request over a valid/ready handshake.

Parameters:
- balance_width, 20, width of balances and amounts.
- id_width, 2, account index width; number of accounts = 2**id_width.
- pin_width, 16, PIN width.
- max_tries, 3, consecutive wrong PINs that lock an account.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_op  in  3  000 withdraw, 001 deposit, 010 inquiry, 011 auth, 100 logout; others are illegal.
- req_id  in  id_width  account index.
- req_pin  in  pin_width  PIN, used by auth only.
- req_amount  in  balance_width  amount for withdraw and deposit.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when resp_valid & resp_ready.
- resp_status  out  3  0 OK, 1 BAD_PIN, 2 LOCKED, 3 INSUFFICIENT, 4 NO_SESSION, 5 OVERFLOW, 6 BAD_OP.
- resp_balance  out  balance_width  account balance after the operation.
- prog_en  in  1  provisioning write.
- prog_id  in  id_width  account to provision.
- prog_pin  in  pin_width  new PIN.
- prog_balance  in  balance_width  new balance.

Behaviour:
- Reset values:
  - resp_valid=0, resp_status=0, resp_balance=0.
  - All balances, PINs, try counts and lock flags are 0.
  - Session closed; state IDLE.
- Reset asserted mid-transaction aborts the transaction with no commit.
- req_ready = (state==IDLE) & !prog_en. It is combinational, so it is 1 after reset release.
- Provisioning:
  - prog_en is honoured only in IDLE.
  - It writes PIN and balance, clears tries and lock, and closes the session if prog_id equals the session id.
  - prog_en outside IDLE is ignored.
- FSM states: IDLE -> CHECK -> COMMIT -> RESP -> IDLE.
  - IDLE: on handshake, latch op, id, pin and amount.
  - CHECK: read the record and compute status and new values.
  - COMMIT: write back the record and session.
  - RESP: resp_valid=1 and outputs stable until resp_ready; leave to IDLE on the handshake cycle.
- Latency: handshake at cycle T -> resp_valid first high at T+3. If resp_ready is held high, the next request can be accepted at T+4.
- Status priority:
  1. Illegal op -> BAD_OP.
  2. Account locked -> LOCKED (auth and any other op).
  3. For withdraw, deposit, inquiry and logout: session closed or session id != req_id -> NO_SESSION.
  4. Op-specific checks, listed below.
- auth:
  - PIN match: tries=0, session opens on req_id, OK.
  - Mismatch: tries+1, BAD_PIN. If tries reaches max_tries: lock=1, session closed, status LOCKED.
  - An auth to another id while a session is open replaces that session.
- withdraw:
  - amount > balance -> INSUFFICIENT, no change.
  - amount == balance is legal and leaves 0.
  - amount 0 -> OK, no change.
- deposit: compute the sum in balance_width+1 bits; carry -> OVERFLOW, no change.
- inquiry: OK, no change.
- logout: closes the session, OK.
- resp_balance: the stored balance after COMMIT, for every status. On BAD_OP or NO_SESSION it is the balance of req_id, read without modification.
- Try counter saturates at max_tries; a locked account is only cleared by provisioning.
- req_valid while not IDLE is not accepted; the requester must hold it.

Decomposition:
- Shared package bank_pkg holds:
  - op codes;
  - status codes;
  - state encodings IDLE/CHECK/COMMIT/RESP;
  - default widths matching the ATM controller (balance_width=20).
- One sub-module bank_account_store:
  - per-account arrays with one combinational read port (id);
  - one write port (id, balance, tries, lock);
  - the provisioning port, which has priority over the write port (they never collide by construction).

Test Plan:
- Provision id1 pin=0x1234 bal=500; auth id1 pin 0x1234 -> resp_valid at T+3, OK, balance 500.
- Then withdraw 200 -> OK, 300. Withdraw 301 -> INSUFFICIENT, 300. Withdraw 300 -> OK, 0.
- Deposit 0xFFFFF onto balance 1 -> OVERFLOW, 1. Deposit 10 onto 1 -> OK, 11.
- Three wrong PINs on id2 -> BAD_PIN, BAD_PIN, LOCKED. Then correct PIN -> LOCKED. Re-provision id2, correct PIN -> OK.
- Withdraw with no session or session on id1 but req_id=3 -> NO_SESSION. Logout, then inquiry id1 -> NO_SESSION. req_op=111 -> BAD_OP.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and outputs stable, req_ready=0. prog_en during RESP is ignored. Async reset during COMMIT -> all outputs 0, and the balance is not changed.

Source files
------------

// File: rtl/bank_pkg.sv
// Shared definitions for the bank account server: op codes, status codes, FSM states
// and the default widths used by the ATM controller side.
// No logic, no latency, no backpressure; types and constants only.
package bank_pkg;

    localparam int BALANCE_WIDTH = 20;
    localparam int ID_WIDTH      = 2;
    localparam int PIN_WIDTH     = 16;
    localparam int MAX_TRIES     = 3;

    typedef enum logic [2:0] {
        OP_WITHDRAW = 3'd0,
        OP_DEPOSIT  = 3'd1,
        OP_INQUIRY  = 3'd2,
        OP_AUTH     = 3'd3,
        OP_LOGOUT   = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_OK           = 3'd0,
        ST_BAD_PIN      = 3'd1,
        ST_LOCKED       = 3'd2,
        ST_INSUFFICIENT = 3'd3,
        ST_NO_SESSION   = 3'd4,
        ST_OVERFLOW     = 3'd5,
        ST_BAD_OP       = 3'd6
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_COMMIT = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'(OP_LOGOUT);
    endfunction

endpackage

// File: rtl/bank_account_store.sv
// Per-account register file: balance, PIN, wrong-PIN count, lock flag.
// Combinational read, writes land on the next clock edge.
// No backpressure; provisioning wins over the update port.
module bank_account_store
    import bank_pkg::*;
#(
    parameter int balance_width = BALANCE_WIDTH,
    parameter int id_width      = ID_WIDTH,
    parameter int pin_width     = PIN_WIDTH,
    parameter int try_width     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [id_width-1:0]      rd_id,
    output logic [balance_width-1:0] rd_balance,
    output logic [pin_width-1:0]     rd_pin,
    output logic [try_width-1:0]     rd_tries,
    output logic                     rd_lock,
    input  logic                     wr_en,
    input  logic [id_width-1:0]      wr_id,
    input  logic [balance_width-1:0] wr_balance,
    input  logic [try_width-1:0]     wr_tries,
    input  logic                     wr_lock,
    input  logic                     prog_en,
    input  logic [id_width-1:0]      prog_id,
    input  logic [pin_width-1:0]     prog_pin,
    input  logic [balance_width-1:0] prog_balance
);
    localparam int N = 2 ** id_width;

    logic [balance_width-1:0] bal_q   [N];
    logic [balance_width-1:0] bal_d   [N];
    logic [pin_width-1:0]     pin_q   [N];
    logic [pin_width-1:0]     pin_d   [N];
    logic [try_width-1:0]     tries_q [N];
    logic [try_width-1:0]     tries_d [N];
    logic                     lock_q  [N];
    logic                     lock_d  [N];

    assign rd_balance = bal_q[rd_id];
    assign rd_pin     = pin_q[rd_id];
    assign rd_tries   = tries_q[rd_id];
    assign rd_lock    = lock_q[rd_id];

    always_comb begin
        bal_d   = bal_q;
        pin_d   = pin_q;
        tries_d = tries_q;
        lock_d  = lock_q;
        if (prog_en) begin
            bal_d[prog_id]   = prog_balance;
            pin_d[prog_id]   = prog_pin;
            tries_d[prog_id] = '0;
            lock_d[prog_id]  = 1'b0;
        end else if (wr_en) begin
            bal_d[wr_id]   = wr_balance;
            tries_d[wr_id] = wr_tries;
            lock_d[wr_id]  = wr_lock;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bal_q   <= '{default: '0};
            pin_q   <= '{default: '0};
            tries_q <= '{default: '0};
            lock_q  <= '{default: 1'b0};
        end else begin
            bal_q   <= bal_d;
            pin_q   <= pin_d;
            tries_q <= tries_d;
            lock_q  <= lock_d;
        end
    end

endmodule

// File: rtl/bank_account_server.sv
// Bank responder: authenticates, tracks one session, applies withdraw/deposit/inquiry.
// Request accepted at T gives resp_valid at T+3; next accept at T+4 with resp_ready high.
// req_ready only in IDLE without provisioning; response held stable until resp_ready.
module bank_account_server
    import bank_pkg::*;
#(
    parameter int balance_width = BALANCE_WIDTH,
    parameter int id_width      = ID_WIDTH,
    parameter int pin_width     = PIN_WIDTH,
    parameter int max_tries     = MAX_TRIES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_op,
    input  logic [id_width-1:0]      req_id,
    input  logic [pin_width-1:0]     req_pin,
    input  logic [balance_width-1:0] req_amount,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [2:0]               resp_status,
    output logic [balance_width-1:0] resp_balance,
    input  logic                     prog_en,
    input  logic [id_width-1:0]      prog_id,
    input  logic [pin_width-1:0]     prog_pin,
    input  logic [balance_width-1:0] prog_balance
);
    localparam int TRY_W = $clog2(max_tries + 1);

    state_e                   state_q, state_d;
    logic [2:0]               op_q, op_d;
    logic [id_width-1:0]      id_q, id_d, sid_q, sid_d, nsid_q, nsid_d;
    logic [pin_width-1:0]     pin_q, pin_d;
    logic [balance_width-1:0] amt_q, amt_d, bal_q, bal_d;
    status_e                  stat_q, stat_d;
    logic [TRY_W-1:0]         ntries_q, ntries_d;
    logic                     nlock_q, nlock_d;
    logic                     sopen_q, sopen_d, nsopen_q, nsopen_d;

    logic [balance_width-1:0] rd_balance;
    logic [pin_width-1:0]     rd_pin;
    logic [TRY_W-1:0]         rd_tries, tries_inc;
    logic                     rd_lock, wr_en, prog_wr;
    logic [balance_width:0]   sum;

    assign prog_wr   = prog_en && (state_q == S_IDLE);
    assign tries_inc = (rd_tries == TRY_W'(max_tries)) ? rd_tries : rd_tries + 1'b1;
    assign sum       = {1'b0, rd_balance} + {1'b0, amt_q};

    bank_account_store #(
        .balance_width(balance_width),
        .id_width     (id_width),
        .pin_width    (pin_width),
        .try_width    (TRY_W)
    ) u_store (
        .clk         (clk),
        .rst         (rst),
        .rd_id       (id_q),
        .rd_balance  (rd_balance),
        .rd_pin      (rd_pin),
        .rd_tries    (rd_tries),
        .rd_lock     (rd_lock),
        .wr_en       (wr_en),
        .wr_id       (id_q),
        .wr_balance  (bal_q),
        .wr_tries    (ntries_q),
        .wr_lock     (nlock_q),
        .prog_en     (prog_wr),
        .prog_id     (prog_id),
        .prog_pin    (prog_pin),
        .prog_balance(prog_balance)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        id_d     = id_q;
        pin_d    = pin_q;
        amt_d    = amt_q;
        bal_d    = bal_q;
        stat_d   = stat_q;
        ntries_d = ntries_q;
        nlock_d  = nlock_q;
        sopen_d  = sopen_q;
        sid_d    = sid_q;
        nsopen_d = nsopen_q;
        nsid_d   = nsid_q;
        wr_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (prog_en) begin
                    if (sopen_q && (prog_id == sid_q)) sopen_d = 1'b0;
                end else if (req_valid) begin
                    op_d    = req_op;
                    id_d    = req_id;
                    pin_d   = req_pin;
                    amt_d   = req_amount;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Default to an unmodified record and session; each branch edits only what it owns.
                bal_d    = rd_balance;
                ntries_d = rd_tries;
                nlock_d  = rd_lock;
                nsopen_d = sopen_q;
                nsid_d   = sid_q;
                stat_d   = ST_OK;
                if (!op_legal(op_q)) begin
                    stat_d = ST_BAD_OP;
                end else if (rd_lock) begin
                    stat_d = ST_LOCKED;
                end else if (op_q != OP_AUTH && !(sopen_q && sid_q == id_q)) begin
                    stat_d = ST_NO_SESSION;
                end else begin
                    case (op_q)
                        OP_AUTH: begin
                            if (pin_q == rd_pin) begin
                                ntries_d = '0;
                                nsopen_d = 1'b1;
                                nsid_d   = id_q;
                            end else begin
                                ntries_d = tries_inc;
                                if (tries_inc == TRY_W'(max_tries)) begin
                                    nlock_d  = 1'b1;
                                    nsopen_d = 1'b0;
                                    stat_d   = ST_LOCKED;
                                end else begin
                                    stat_d = ST_BAD_PIN;
                                end
                            end
                        end
                        OP_WITHDRAW: begin
                            if (amt_q > rd_balance) stat_d = ST_INSUFFICIENT;
                            else                    bal_d  = rd_balance - amt_q;
                        end
                        OP_DEPOSIT: begin
                            if (sum[balance_width]) stat_d = ST_OVERFLOW;
                            else                    bal_d  = sum[balance_width-1:0];
                        end
                        OP_LOGOUT: nsopen_d = 1'b0;
                        default: ;
                    endcase
                end
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                wr_en   = 1'b1;
                sopen_d = nsopen_q;
                sid_d   = nsid_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            id_q     <= '0;
            pin_q    <= '0;
            amt_q    <= '0;
            bal_q    <= '0;
            stat_q   <= ST_OK;
            ntries_q <= '0;
            nlock_q  <= 1'b0;
            sopen_q  <= 1'b0;
            sid_q    <= '0;
            nsopen_q <= 1'b0;
            nsid_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            id_q     <= id_d;
            pin_q    <= pin_d;
            amt_q    <= amt_d;
            bal_q    <= bal_d;
            stat_q   <= stat_d;
            ntries_q <= ntries_d;
            nlock_q  <= nlock_d;
            sopen_q  <= sopen_d;
            sid_q    <= sid_d;
            nsopen_q <= nsopen_d;
            nsid_q   <= nsid_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE) && !prog_en;
    assign resp_valid   = (state_q == S_RESP);
    assign resp_status  = stat_q;
    assign resp_balance = bal_q;

endmodule

// File: tb/tb_bank_account_server.sv
// Bench for bank_account_server: directed scenarios with literal expectations, then random
// traffic checked every cycle against an account-level reference model.
module tb_bank_account_server;
    localparam int BW   = 20;
    localparam int IW   = 2;
    localparam int PW   = 16;
    localparam int MT   = 3;
    localparam int N    = 4;
    localparam int BMAX = (1 << BW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0, req_ready;
    logic [2:0]    req_op = '0;
    logic [IW-1:0] req_id = '0;
    logic [PW-1:0] req_pin = '0;
    logic [BW-1:0] req_amount = '0;
    logic          resp_valid, resp_ready = 1'b1;
    logic [2:0]    resp_status;
    logic [BW-1:0] resp_balance;
    logic          prog_en = 1'b0;
    logic [IW-1:0] prog_id = '0;
    logic [PW-1:0] prog_pin = '0;
    logic [BW-1:0] prog_balance = '0;

    int n_checks = 0;
    int n_errors = 0;

    bank_account_server #(.balance_width(BW), .id_width(IW), .pin_width(PW), .max_tries(MT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_id(req_id),
        .req_pin(req_pin), .req_amount(req_amount),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
        .resp_balance(resp_balance),
        .prog_en(prog_en), .prog_id(prog_id), .prog_pin(prog_pin), .prog_balance(prog_balance)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accounts as plain arrays, one outstanding request with a fixed delay.
    int m_bal[N], m_pin[N], m_tries[N];
    bit m_lock[N];
    bit m_sopen;
    int m_sid;
    bit m_pend;
    int m_cnt;
    int e_st, e_bal;

    task automatic model_req(input int op, input int id, input int pin, input int amt);
        if (op > 4)                                    e_st = 6;
        else if (m_lock[id])                           e_st = 2;
        else if (op != 3 && !(m_sopen && m_sid == id)) e_st = 4;
        else begin
            e_st = 0;
            case (op)
                0: if (amt > m_bal[id]) e_st = 3; else m_bal[id] -= amt;
                1: if (m_bal[id] + amt > BMAX) e_st = 5; else m_bal[id] += amt;
                3: begin
                    if (pin == m_pin[id]) begin
                        m_tries[id] = 0; m_sopen = 1; m_sid = id;
                    end else begin
                        m_tries[id]++;
                        if (m_tries[id] >= MT) begin
                            m_lock[id] = 1; m_sopen = 0; e_st = 2;
                        end else e_st = 1;
                    end
                end
                4: m_sopen = 0;
                default: ;
            endcase
        end
        e_bal = m_bal[id];
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                m_bal[i] = 0; m_pin[i] = 0; m_tries[i] = 0; m_lock[i] = 0;
            end
            m_sopen = 0; m_sid = 0; m_pend = 0; m_cnt = 0; e_st = 0; e_bal = 0;
        end else if (m_pend) begin
            if (m_cnt > 0) m_cnt--;
            else if (resp_ready) m_pend = 0;
        end else if (prog_en) begin
            m_bal[prog_id] = prog_balance; m_pin[prog_id] = prog_pin;
            m_tries[prog_id] = 0; m_lock[prog_id] = 0;
            if (m_sopen && m_sid == int'(prog_id)) m_sopen = 0;
        end else if (req_valid) begin
            model_req(req_op, req_id, req_pin, req_amount);
            m_pend = 1; m_cnt = 2;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("req_ready", req_ready, !m_pend && !prog_en);
            chk("resp_valid", resp_valid, m_pend && m_cnt == 0);
            if (m_pend && m_cnt == 0) begin
                chk("model_status", resp_status, e_st);
                chk("model_balance", resp_balance, e_bal);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic prog(input int id, input int pin, input int bal);
        prog_en = 1; prog_id = IW'(id); prog_pin = PW'(pin); prog_balance = BW'(bal);
        tick();
        prog_en = 0;
    endtask

    task automatic txn(input string name, input int op, input int id, input int pin, input int amt,
                       input int exp_st, input int exp_bal);
        int k, lat;
        req_op = 3'(op); req_id = IW'(id); req_pin = PW'(pin); req_amount = BW'(amt);
        req_valid = 1;
        k = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            if (++k > 50) begin chk({name, "_accept_timeout"}, 0, 1); break; end
        end
        tick();
        req_valid = 0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (resp_valid) break;
            if (++lat > 50) begin chk({name, "_resp_timeout"}, 0, 1); break; end
        end
        chk({name, "_latency"}, lat, 3);
        chk({name, "_status"}, resp_status, exp_st);
        chk({name, "_balance"}, resp_balance, exp_bal);
        tick();
    endtask

    initial begin
        bit acc;
        int r, id, a;
        repeat (2) tick();
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_status", resp_status, 0);
        chk("rst_resp_balance", resp_balance, 0);
        rst = 1;
        #1 chk("rst_req_ready", req_ready, 1);
        tick();

        prog(1, 'h1234, 500);
        txn("auth1", 3, 1, 'h1234, 0, 0, 500);
        txn("wd200", 0, 1, 0, 200, 0, 300);
        txn("wd301", 0, 1, 0, 301, 3, 300);
        txn("wd300", 0, 1, 0, 300, 0, 0);
        txn("wd0", 0, 1, 0, 0, 0, 0);
        txn("dep1", 1, 1, 0, 1, 0, 1);
        txn("dep_ovf", 1, 1, 0, 'hFFFFF, 5, 1);
        txn("dep10", 1, 1, 0, 10, 0, 11);

        prog(2, 'hBEEF, 77);
        txn("bad1", 3, 2, 'h1111, 0, 1, 77);
        txn("bad2", 3, 2, 'h2222, 0, 1, 77);
        txn("bad3", 3, 2, 'h3333, 0, 2, 77);
        txn("locked_ok_pin", 3, 2, 'hBEEF, 0, 2, 77);
        prog(2, 'hBEEF, 77);
        txn("auth2_after_prog", 3, 2, 'hBEEF, 0, 0, 77);

        txn("wd_id3_sess2", 0, 3, 0, 5, 4, 0);
        txn("auth1_again", 3, 1, 'h1234, 0, 0, 11);
        txn("wd_id3_sess1", 0, 3, 0, 5, 4, 0);
        txn("logout1", 4, 1, 0, 0, 0, 11);
        txn("inq_after_logout", 2, 1, 0, 0, 4, 11);
        txn("wd_no_session", 0, 1, 0, 1, 4, 11);
        txn("bad_op", 7, 1, 0, 0, 6, 11);

        txn("auth1_bp", 3, 1, 'h1234, 0, 0, 11);
        resp_ready = 0;
        txn("inq_bp", 2, 1, 0, 0, 0, 11);
        prog(1, 'h9999, 999);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid", resp_valid, 1);
            chk("bp_status", resp_status, 0);
            chk("bp_balance", resp_balance, 11);
            chk("bp_req_ready", req_ready, 0);
            tick();
        end
        resp_ready = 1;
        tick();
        txn("inq_after_bp", 2, 1, 0, 0, 0, 11);

        req_op = 3'd1; req_id = 2'd1; req_amount = BW'(50); req_valid = 1;
        a = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            if (++a > 50) begin chk("rst_commit_accept_timeout", 0, 1); break; end
        end
        tick();
        req_valid = 0;
        tick();
        rst = 0;
        #1;
        chk("rst_commit_valid", resp_valid, 0);
        chk("rst_commit_status", resp_status, 0);
        chk("rst_commit_balance", resp_balance, 0);
        chk("rst_commit_ready", req_ready, 1);
        #1 rst = 1;
        tick();
        txn("auth_after_rst", 3, 1, 0, 0, 0, 0);

        for (int i = 0; i < N; i++) prog(i, $urandom_range(0, 65535), $urandom_range(0, 2000));
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            acc = req_valid && req_ready;
            tick();
            resp_ready   = ($urandom_range(0, 3) != 0);
            prog_en      = ($urandom_range(0, 39) == 0);
            prog_id      = IW'($urandom_range(0, N - 1));
            prog_pin     = PW'($urandom_range(0, 65535));
            prog_balance = ($urandom_range(0, 3) == 0) ? BW'($urandom_range(BMAX - 100, BMAX))
                                                       : BW'($urandom_range(0, 3000));
            if (acc || !req_valid) begin
                if ($urandom_range(0, 1) == 1) begin
                    r  = $urandom_range(0, 15);
                    id = $urandom_range(0, N - 1);
                    req_op = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 8) ? 3'd2 :
                             (r < 12) ? 3'd3 : (r < 14) ? 3'd4 : 3'($urandom_range(5, 7));
                    req_id  = IW'(id);
                    req_pin = ($urandom_range(0, 3) != 0) ? PW'(m_pin[id]) : PW'($urandom_range(0, 65535));
                    case ($urandom_range(0, 3))
                        0: a = m_bal[id];
                        1: a = $urandom_range(BMAX - 50, BMAX);
                        default: a = $urandom_range(0, 400);
                    endcase
                    req_amount = BW'(a);
                    req_valid  = 1;
                end else req_valid = 0;
            end
        end
        req_valid = 0; prog_en = 0; resp_ready = 1;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
